// File: rtl/router_pkg.sv
// Shared types for the router ingress controller: FSM state encoding,
// the per-state strobe bundle and the state-to-strobe decode.
package router_pkg;

  localparam int         NUM_PORTS    = 3;
  localparam logic [1:0] ADDR_INVALID = 2'd3;

  typedef enum logic [2:0] {
    DECODE_ADDRESS     = 3'd0,
    LOAD_FIRST_DATA    = 3'd1,
    LOAD_DATA          = 3'd2,
    WAIT_TILL_EMPTY    = 3'd3,
    FIFO_FULL_STATE    = 3'd4,
    LOAD_AFTER_FULL    = 3'd5,
    LOAD_PARITY        = 3'd6,
    CHECK_PARITY_ERROR = 3'd7
  } router_state_t;

  typedef struct packed {
    logic detect_add;
    logic lfd_state;
    logic ld_state;
    logic laf_state;
    logic full_state;
    logic rst_int_reg;
    logic write_enb_reg;
    logic busy;
  } ctrl_out_t;

  // Moore decode: each strobe is a pure function of the state it will describe.
  function automatic ctrl_out_t decode_outputs(input router_state_t st);
    ctrl_out_t o;
    o = '0;
    case (st)
      DECODE_ADDRESS:     o.detect_add = 1'b1;
      LOAD_FIRST_DATA: begin
        o.lfd_state = 1'b1;
        o.busy      = 1'b1;
      end
      LOAD_DATA: begin
        o.ld_state      = 1'b1;
        o.write_enb_reg = 1'b1;
      end
      WAIT_TILL_EMPTY:    o.busy = 1'b1;
      FIFO_FULL_STATE: begin
        o.full_state = 1'b1;
        o.busy       = 1'b1;
      end
      LOAD_AFTER_FULL: begin
        o.laf_state     = 1'b1;
        o.write_enb_reg = 1'b1;
        o.busy          = 1'b1;
      end
      LOAD_PARITY: begin
        o.write_enb_reg = 1'b1;
        o.busy          = 1'b1;
      end
      CHECK_PARITY_ERROR: begin
        o.rst_int_reg = 1'b1;
        o.busy        = 1'b1;
      end
      default:            o.detect_add = 1'b1;
    endcase
    return o;
  endfunction

endpackage

// File: rtl/router_ctrl_fsm_if.sv
// Ingress-side bundle of the router controller: source handshake, FIFO
// status, register-block feedback and the phase strobes back out.
interface router_ctrl_fsm_if;

  logic       pkt_valid;
  logic [1:0] data_in;
  logic       fifo_full_0;
  logic       fifo_full_1;
  logic       fifo_full_2;
  logic       fifo_empty_0;
  logic       fifo_empty_1;
  logic       fifo_empty_2;
  logic       soft_reset_0;
  logic       soft_reset_1;
  logic       soft_reset_2;
  logic       parity_done;
  logic       low_pkt_valid;

  logic       detect_add;
  logic       lfd_state;
  logic       ld_state;
  logic       laf_state;
  logic       full_state;
  logic       rst_int_reg;
  logic       write_enb_reg;
  logic       busy;
  logic [1:0] sel_addr;

  // Source / environment side.
  modport master (
    output pkt_valid, data_in,
    output fifo_full_0, fifo_full_1, fifo_full_2,
    output fifo_empty_0, fifo_empty_1, fifo_empty_2,
    output soft_reset_0, soft_reset_1, soft_reset_2,
    output parity_done, low_pkt_valid,
    input  detect_add, lfd_state, ld_state, laf_state, full_state,
    input  rst_int_reg, write_enb_reg, busy, sel_addr
  );

  // Controller side.
  modport slave (
    input  pkt_valid, data_in,
    input  fifo_full_0, fifo_full_1, fifo_full_2,
    input  fifo_empty_0, fifo_empty_1, fifo_empty_2,
    input  soft_reset_0, soft_reset_1, soft_reset_2,
    input  parity_done, low_pkt_valid,
    output detect_add, lfd_state, ld_state, laf_state, full_state,
    output rst_int_reg, write_enb_reg, busy, sel_addr
  );

endinterface

// File: rtl/router_port_sel.sv
// Picks the full/empty/soft-reset status of one destination FIFO by address.
// The invalid address selects nothing, so all three outputs read as 0.
module router_port_sel
  import router_pkg::*;
(
  input  logic [1:0]           addr_i,
  input  logic [NUM_PORTS-1:0] full_i,
  input  logic [NUM_PORTS-1:0] empty_i,
  input  logic [NUM_PORTS-1:0] soft_reset_i,
  output logic                 full_o,
  output logic                 empty_o,
  output logic                 soft_reset_o
);

  // 3:1 status mux.
  always_comb begin
    full_o       = 1'b0;
    empty_o      = 1'b0;
    soft_reset_o = 1'b0;
    case (addr_i)
      2'd0: begin
        full_o       = full_i[0];
        empty_o      = empty_i[0];
        soft_reset_o = soft_reset_i[0];
      end
      2'd1: begin
        full_o       = full_i[1];
        empty_o      = empty_i[1];
        soft_reset_o = soft_reset_i[1];
      end
      2'd2: begin
        full_o       = full_i[2];
        empty_o      = empty_i[2];
        soft_reset_o = soft_reset_i[2];
      end
      default: begin
        full_o       = 1'b0;
        empty_o      = 1'b0;
        soft_reset_o = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/router_ctrl_fsm.sv
// Packet-sequencing controller for one router ingress: decodes the header
// address, waits for the destination FIFO, and steps the datapath phases.
module router_ctrl_fsm
  import router_pkg::*;
(
  input  logic              clock,
  input  logic              resetn,
  router_ctrl_fsm_if.slave  bus
);

  router_state_t          state_q;
  router_state_t          state_d;
  router_state_t          trans_state_s;
  logic [1:0]             sel_addr_q;
  logic [1:0]             sel_addr_d;
  ctrl_out_t              out_q;
  ctrl_out_t              out_d;

  logic [1:0]             lookup_addr_s;
  logic [NUM_PORTS-1:0]   full_vec_s;
  logic [NUM_PORTS-1:0]   empty_vec_s;
  logic [NUM_PORTS-1:0]   srst_vec_s;
  logic                   f_full_s;
  logic                   f_empty_s;
  logic                   f_srst_s;
  logic                   hdr_ok_s;

  assign full_vec_s  = {bus.fifo_full_2,  bus.fifo_full_1,  bus.fifo_full_0};
  assign empty_vec_s = {bus.fifo_empty_2, bus.fifo_empty_1, bus.fifo_empty_0};
  assign srst_vec_s  = {bus.soft_reset_2, bus.soft_reset_1, bus.soft_reset_0};

  // The header byte is not latched yet while decoding, so look it up directly.
  assign lookup_addr_s = (state_q == DECODE_ADDRESS) ? bus.data_in : sel_addr_q;
  assign hdr_ok_s      = bus.pkt_valid && (bus.data_in != ADDR_INVALID);

  router_port_sel u_port_sel (
    .addr_i       (lookup_addr_s),
    .full_i       (full_vec_s),
    .empty_i      (empty_vec_s),
    .soft_reset_i (srst_vec_s),
    .full_o       (f_full_s),
    .empty_o      (f_empty_s),
    .soft_reset_o (f_srst_s)
  );

  // Packet-phase transitions, before the soft-reset override.
  always_comb begin
    trans_state_s = state_q;
    case (state_q)
      DECODE_ADDRESS: begin
        if (hdr_ok_s) begin
          trans_state_s = f_empty_s ? LOAD_FIRST_DATA : WAIT_TILL_EMPTY;
        end else begin
          trans_state_s = DECODE_ADDRESS;
        end
      end
      LOAD_FIRST_DATA: trans_state_s = LOAD_DATA;
      LOAD_DATA: begin
        if (f_full_s) begin
          trans_state_s = FIFO_FULL_STATE;
        end else if (!bus.pkt_valid) begin
          trans_state_s = LOAD_PARITY;
        end else begin
          trans_state_s = LOAD_DATA;
        end
      end
      FIFO_FULL_STATE: trans_state_s = f_full_s ? FIFO_FULL_STATE : LOAD_AFTER_FULL;
      LOAD_AFTER_FULL: begin
        if (bus.parity_done) begin
          trans_state_s = DECODE_ADDRESS;
        end else if (bus.low_pkt_valid) begin
          trans_state_s = LOAD_PARITY;
        end else begin
          trans_state_s = LOAD_DATA;
        end
      end
      LOAD_PARITY:        trans_state_s = CHECK_PARITY_ERROR;
      CHECK_PARITY_ERROR: trans_state_s = f_full_s ? FIFO_FULL_STATE : DECODE_ADDRESS;
      WAIT_TILL_EMPTY:    trans_state_s = f_empty_s ? LOAD_FIRST_DATA : WAIT_TILL_EMPTY;
      default:            trans_state_s = DECODE_ADDRESS;
    endcase
  end

  // Soft reset of the selected port abandons the packet; the address latch and
  // the registered strobes follow the final next state.
  always_comb begin
    state_d    = trans_state_s;
    sel_addr_d = sel_addr_q;
    if ((state_q != DECODE_ADDRESS) && f_srst_s) begin
      state_d = DECODE_ADDRESS;
    end else begin
      state_d = trans_state_s;
    end
    if ((state_q == DECODE_ADDRESS) && hdr_ok_s) begin
      sel_addr_d = bus.data_in;
    end else begin
      sel_addr_d = sel_addr_q;
    end
    out_d = decode_outputs(state_d);
  end

  // State, address latch and strobes registered together so outputs line up
  // with the state they describe.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_q    <= DECODE_ADDRESS;
      sel_addr_q <= 2'd0;
      out_q      <= decode_outputs(DECODE_ADDRESS);
    end else begin
      state_q    <= state_d;
      sel_addr_q <= sel_addr_d;
      out_q      <= out_d;
    end
  end

  assign bus.detect_add    = out_q.detect_add;
  assign bus.lfd_state     = out_q.lfd_state;
  assign bus.ld_state      = out_q.ld_state;
  assign bus.laf_state     = out_q.laf_state;
  assign bus.full_state    = out_q.full_state;
  assign bus.rst_int_reg   = out_q.rst_int_reg;
  assign bus.write_enb_reg = out_q.write_enb_reg;
  assign bus.busy          = out_q.busy;
  assign bus.sel_addr      = sel_addr_q;

endmodule

// File: tb/tb_router_ctrl_fsm.sv
// Directed scenarios plus random traffic, every cycle compared against a
// phase-level model of the ingress controller.
module tb_router_ctrl_fsm;

  localparam int P_DA  = 0;
  localparam int P_LFD = 1;
  localparam int P_LD  = 2;
  localparam int P_WTE = 3;
  localparam int P_FFS = 4;
  localparam int P_LAF = 5;
  localparam int P_LP  = 6;
  localparam int P_CPE = 7;

  logic clock;
  logic resetn;
  router_ctrl_fsm_if bus ();

  router_ctrl_fsm dut (
    .clock  (clock),
    .resetn (resetn),
    .bus    (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int checks;
  int failures;
  int cnt;

  logic       rst_v;
  logic       pkt;
  logic [1:0] data;
  logic [2:0] ff;
  logic [2:0] fe;
  logic [2:0] sr;
  logic       pd;
  logic       lpv;

  int         m_ph;
  logic [1:0] m_sel;

  function automatic logic pick(input logic [2:0] v, input logic [1:0] i);
    case (i)
      2'd0:    return v[0];
      2'd1:    return v[1];
      2'd2:    return v[2];
      default: return 1'b0;
    endcase
  endfunction

  // {detect_add, lfd, ld, laf, full, rst_int_reg, write_enb_reg, busy}
  function automatic logic [7:0] exp_out(input int ph);
    logic [7:0] e;
    e[7] = (ph == P_DA);
    e[6] = (ph == P_LFD);
    e[5] = (ph == P_LD);
    e[4] = (ph == P_LAF);
    e[3] = (ph == P_FFS);
    e[2] = (ph == P_CPE);
    e[1] = (ph == P_LD) || (ph == P_LAF) || (ph == P_LP);
    e[0] = !((ph == P_DA) || (ph == P_LD));
    return e;
  endfunction

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive();
    resetn            = rst_v;
    bus.pkt_valid     = pkt;
    bus.data_in       = data;
    bus.fifo_full_0   = ff[0];
    bus.fifo_full_1   = ff[1];
    bus.fifo_full_2   = ff[2];
    bus.fifo_empty_0  = fe[0];
    bus.fifo_empty_1  = fe[1];
    bus.fifo_empty_2  = fe[2];
    bus.soft_reset_0  = sr[0];
    bus.soft_reset_1  = sr[1];
    bus.soft_reset_2  = sr[2];
    bus.parity_done   = pd;
    bus.low_pkt_valid = lpv;
  endtask

  // Apply inputs, advance the model one packet phase, clock, compare.
  task automatic step(input string tag);
    int         nph;
    logic [1:0] nsel;
    logic [9:0] obs;
    drive();
    nph  = m_ph;
    nsel = m_sel;
    if (!rst_v) begin
      nph  = P_DA;
      nsel = 2'd0;
    end else if (m_ph != P_DA && pick(sr, m_sel)) begin
      nph = P_DA;
    end else begin
      case (m_ph)
        P_DA: if (pkt && data != 2'd3) begin
          nsel = data;
          nph  = pick(fe, data) ? P_LFD : P_WTE;
        end
        P_LFD: nph = P_LD;
        P_LD:  nph = pick(ff, m_sel) ? P_FFS : (!pkt ? P_LP : P_LD);
        P_FFS: nph = pick(ff, m_sel) ? P_FFS : P_LAF;
        P_LAF: nph = pd ? P_DA : (lpv ? P_LP : P_LD);
        P_LP:  nph = P_CPE;
        P_CPE: nph = pick(ff, m_sel) ? P_FFS : P_DA;
        P_WTE: nph = pick(fe, m_sel) ? P_LFD : P_WTE;
        default: nph = P_DA;
      endcase
    end
    @(posedge clock);
    #1;
    m_ph  = nph;
    m_sel = nsel;
    obs = {bus.detect_add, bus.lfd_state, bus.ld_state, bus.laf_state, bus.full_state,
           bus.rst_int_reg, bus.write_enb_reg, bus.busy, bus.sel_addr};
    check(tag, {6'd0, obs}, {6'd0, exp_out(m_ph), m_sel});
  endtask

  initial begin
    checks = 0; failures = 0; cnt = 0;
    rst_v = 1'b0; pkt = 1'b0; data = 2'd0; ff = 3'b000; fe = 3'b111;
    sr = 3'b000; pd = 1'b0; lpv = 1'b0;
    m_ph = P_DA; m_sel = 2'd0;
    drive();

    step("reset0");
    step("reset1");
    check("reset_detect", {15'd0, bus.detect_add}, 16'd1);
    check("reset_busy", {15'd0, bus.busy}, 16'd0);
    check("reset_sel", {14'd0, bus.sel_addr}, 16'd0);

    // Header to port 1, four payload bytes, parity.
    rst_v = 1'b1; pkt = 1'b1; data = 2'd1; cnt = 0;
    step("hdr1");
    cnt += int'(bus.write_enb_reg);
    check("hdr1_lfd", {15'd0, bus.lfd_state}, 16'd1);
    check("hdr1_busy", {15'd0, bus.busy}, 16'd1);
    check("hdr1_sel", {14'd0, bus.sel_addr}, 16'd1);
    for (int i = 0; i < 4; i++) begin
      data = 2'($urandom);
      step("payload");
      cnt += int'(bus.write_enb_reg);
      check("payload_busy", {15'd0, bus.busy}, 16'd0);
    end
    pkt = 1'b0;
    step("to_parity");
    cnt += int'(bus.write_enb_reg);
    step("check_parity");
    cnt += int'(bus.write_enb_reg);
    check("rst_int_reg", {15'd0, bus.rst_int_reg}, 16'd1);
    step("back_decode");
    check("wen_cycles", 16'(cnt), 16'd5);

    // Header to port 2 while its FIFO still drains.
    pkt = 1'b1; data = 2'd2; fe = 3'b011; cnt = 0;
    for (int i = 0; i < 5; i++) begin
      step("wait_empty");
      cnt += int'(bus.busy);
    end
    check("wte_busy_cycles", 16'(cnt), 16'd5);
    fe = 3'b111;
    step("empty_rise");
    check("wte_to_lfd", {15'd0, bus.lfd_state}, 16'd1);
    step("p2_ld");
    pkt = 1'b0;
    step("p2_lp");
    step("p2_cpe");
    step("p2_da");

    // Port 0 full for three cycles in LOAD_DATA.
    pkt = 1'b1; data = 2'd0;
    step("p0_lfd");
    step("p0_ld");
    ff = 3'b001;
    for (int i = 0; i < 3; i++) begin
      step("p0_full");
      check("full_state", {15'd0, bus.full_state}, 16'd1);
    end
    ff = 3'b000; lpv = 1'b1; pd = 1'b0;
    step("p0_laf");
    check("laf_state", {15'd0, bus.laf_state}, 16'd1);
    step("p0_lp");
    check("lp_wen", {15'd0, bus.write_enb_reg}, 16'd1);
    lpv = 1'b0; pkt = 1'b0;
    step("p0_cpe");
    step("p0_da");

    // Invalid address is dropped.
    pkt = 1'b1; data = 2'd3;
    step("addr3");
    check("addr3_busy", {15'd0, bus.busy}, 16'd0);
    check("addr3_sel", {14'd0, bus.sel_addr}, 16'd0);
    pkt = 1'b0;

    // Soft reset: non-selected port ignored, selected port aborts.
    pkt = 1'b1; data = 2'd1;
    step("sr_lfd");
    step("sr_ld");
    sr = 3'b001;
    step("sr_other");
    check("sr_other_ld", {15'd0, bus.ld_state}, 16'd1);
    sr = 3'b010;
    step("sr_sel");
    check("sr_sel_da", {15'd0, bus.detect_add}, 16'd1);
    sr = 3'b000; pkt = 1'b0;

    // Full and end-of-packet together: full wins.
    pkt = 1'b1; data = 2'd2;
    step("fp_lfd");
    step("fp_ld");
    pkt = 1'b0; ff = 3'b100;
    step("fp_both");
    check("full_wins", {15'd0, bus.full_state}, 16'd1);
    ff = 3'b000; pd = 1'b1;
    step("fp_laf");
    step("fp_done");
    check("parity_done_da", {15'd0, bus.detect_add}, 16'd1);
    pd = 1'b0;

    // resetn together with soft reset mid-packet.
    pkt = 1'b1; data = 2'd1;
    step("rs_lfd");
    step("rs_ld");
    rst_v = 1'b0; sr = 3'b010;
    step("rs_both");
    check("rs_sel", {14'd0, bus.sel_addr}, 16'd0);
    rst_v = 1'b1; sr = 3'b000; pkt = 1'b0;
    step("rs_idle");

    // Random traffic.
    for (int i = 0; i < 600; i++) begin
      rst_v = ($urandom_range(0, 63) != 0);
      pkt   = 1'($urandom);
      data  = 2'($urandom);
      for (int p = 0; p < 3; p++) begin
        ff[p] = ($urandom_range(0, 3) == 0);
        fe[p] = ($urandom_range(0, 3) != 0);
        sr[p] = ($urandom_range(0, 15) == 0);
      end
      pd  = ($urandom_range(0, 3) == 0);
      lpv = 1'($urandom);
      step("random");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/router_ctrl_fsm.md
# router_ctrl_fsm

Packet-sequencing controller for one router ingress. It decodes the header address, waits for the destination FIFO to drain, and steps the register/parity datapath through header, payload, full-stall and parity phases. It drives the datapath phase strobes (detect_add, lfd_state, ld_state, laf_state, full_state, rst_int_reg), the FIFO write enable and the source `busy` handshake. It sits between the ingress port, the register block and the three output FIFOs.

## Interface
- No parameters. Three output ports, fixed.
- clock  in  1  rising-edge clock
- resetn  in  1  reset; synchronous, active-low
- pkt_valid  in  1  source drives a packet byte this cycle
- data_in  in  2  header address bits [1:0]; 3 is an invalid address
- fifo_full_0/1/2  in  1  per-destination FIFO full
- fifo_empty_0/1/2  in  1  per-destination FIFO empty
- soft_reset_0/1/2  in  1  per-destination read-timeout soft reset
- parity_done  in  1  from the register block
- low_pkt_valid  in  1  from the register block
- detect_add, lfd_state, ld_state, laf_state, full_state, rst_int_reg  out  1  phase strobes to the register block
- write_enb_reg  out  1  write strobe to the selected FIFO
- busy  out  1  source must hold its current byte
- sel_addr  out  2  latched destination address

## Operation
- States: DECODE_ADDRESS (reset state), LOAD_FIRST_DATA, LOAD_DATA, WAIT_TILL_EMPTY, FIFO_FULL_STATE, LOAD_AFTER_FULL, LOAD_PARITY, CHECK_PARITY_ERROR.
- sel_addr loads data_in when the state is DECODE_ADDRESS, pkt_valid=1 and data_in != 3. It holds otherwise.
- f_full and f_empty are the fifo_full_x and fifo_empty_x selected by sel_addr. In DECODE_ADDRESS, f_empty is indexed by data_in directly.
- Transitions:
  - DECODE_ADDRESS, pkt_valid=1, addr != 3: go to LOAD_FIRST_DATA if f_empty=1, otherwise WAIT_TILL_EMPTY.
  - DECODE_ADDRESS, addr == 3 or pkt_valid=0: stay. An addr-3 packet is dropped.
  - LOAD_FIRST_DATA: go to LOAD_DATA unconditionally.
  - LOAD_DATA: go to FIFO_FULL_STATE if f_full=1. Otherwise go to LOAD_PARITY if pkt_valid=0. Otherwise stay.
  - FIFO_FULL_STATE: go to LOAD_AFTER_FULL when f_full=0. Otherwise stay.
  - LOAD_AFTER_FULL: go to DECODE_ADDRESS if parity_done=1. Otherwise go to LOAD_PARITY if low_pkt_valid=1. Otherwise go to LOAD_DATA.
  - LOAD_PARITY: go to CHECK_PARITY_ERROR.
  - CHECK_PARITY_ERROR: go to FIFO_FULL_STATE if f_full=1. Otherwise go to DECODE_ADDRESS.
  - WAIT_TILL_EMPTY: go to LOAD_FIRST_DATA when f_empty=1. Otherwise stay.
- Soft reset: soft_reset_[sel_addr]=1 in any state except DECODE_ADDRESS forces DECODE_ADDRESS next cycle.
  - It outranks every transition above. Only resetn outranks it.
  - Soft resets of non-selected ports are ignored.
- Moore outputs, one state each:
  - detect_add = DECODE_ADDRESS
  - lfd_state = LOAD_FIRST_DATA
  - ld_state = LOAD_DATA
  - full_state = FIFO_FULL_STATE
  - laf_state = LOAD_AFTER_FULL
  - rst_int_reg = CHECK_PARITY_ERROR
- write_enb_reg = 1 in LOAD_DATA, LOAD_AFTER_FULL and LOAD_PARITY.
- busy = 1 in every state except DECODE_ADDRESS and LOAD_DATA.
- Reset values: state DECODE_ADDRESS, sel_addr 0. Hence detect_add=1 and every other output 0.

## Timing
- Outputs decode registered state only: no combinational input-to-output path.
- A header accepted at edge N gives lfd_state=1 in cycle N+1 and ld_state=1 in N+2.
- busy rises in the cycle after the state change. While busy=1 the source holds data and pkt_valid.
- resetn mid-packet: DECODE_ADDRESS after the edge, and the packet is abandoned.
- f_full and pkt_valid=0 together in LOAD_DATA: the full check wins, so the next state is FIFO_FULL_STATE.
- Soft reset and resetn together: resetn wins, with the identical resulting state.

## Structure
- Shared package router_pkg holds:
  - state enum router_state_t (3-bit encoding);
  - ADDR_INVALID = 2'd3;
  - NUM_PORTS = 3.
- One sub-module, router_port_sel: combinational 3:1 select of full, empty and soft_reset by address.

## Test plan
- Reset, then header data_in=2'b01 with fifo_empty_1=1 → LOAD_FIRST_DATA, then LOAD_DATA; sel_addr=1; busy=1 only in the lfd cycle.
- Header addr 2 with fifo_empty_2=0 for 5 cycles → WAIT_TILL_EMPTY held and busy=1 for 5 cycles; LOAD_FIRST_DATA the cycle after empty rises.
- 4 payload bytes, then pkt_valid=0 → LOAD_PARITY → CHECK_PARITY_ERROR (rst_int_reg=1) → DECODE_ADDRESS; write_enb_reg=1 for 5 cycles.
- fifo_full_0=1 for 3 cycles in LOAD_DATA, low_pkt_valid=1, parity_done=0 → FIFO_FULL_STATE×3 → LOAD_AFTER_FULL → LOAD_PARITY.
- Header addr 3 → stays in DECODE_ADDRESS, busy=0, sel_addr unchanged.
- soft_reset_1 in LOAD_DATA for port 1 → DECODE_ADDRESS next cycle; soft_reset_0 at the same point → no effect.
